// File: rtl/fp8_cmd_sched_if.sv
// Command, response and arithmetic-unit signals of the FP8 command scheduler.
// slave  : the scheduler's view (takes commands, drives the unit, returns responses).
// master : the surrounding logic's view (issues commands, models the unit, takes responses).
interface fp8_cmd_sched_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic             unit_start;
  logic [7:0]       unit_a;
  logic [7:0]       unit_b;
  logic [1:0]       unit_op;
  logic             unit_done;
  logic [7:0]       unit_result;
  logic [3:0]       unit_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output unit_start, unit_a, unit_b, unit_op,
    input  unit_done, unit_result, unit_flags,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  unit_start, unit_a, unit_b, unit_op,
    output unit_done, unit_result, unit_flags,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout,
    output rsp_ready
  );
endinterface

// File: rtl/fp8_cmd_sched.sv
// FP8 command scheduler: queues operand/opcode/tag commands in a small FIFO,
// issues them one at a time to the FP8 arithmetic unit over start/done, and
// returns result, flags and tag on a valid/ready response channel.
// Reserved opcode 11 is answered directly without starting the unit; a unit
// that stays silent for TIMEOUT wait cycles yields a timeout response.
// Optional build macro FP8_SCHED_STATS_EN adds saturating response counters
// stat_done (all handshakes) and stat_timeouts (handshakes with rsp_timeout).
module fp8_cmd_sched #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  fp8_cmd_sched_if.slave         bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef FP8_SCHED_STATS_EN
  ,
  output logic [15:0]            stat_done,
  output logic [7:0]             stat_timeouts
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 18 + TAG_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [7:0]       ua_q, ua_d, ub_q, ub_d;
  logic [1:0]       uop_q, uop_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       res_q, res_d;
  logic [3:0]       flg_q, flg_d;
  logic             tmo_q, tmo_d;
  logic [EW-1:0]    head;
  logic             push, pop;

  assign bus.cmd_ready   = (count_q != CW'(DEPTH));
  assign bus.unit_start  = (state_q == ISSUE);
  assign bus.unit_a      = ua_q;
  assign bus.unit_b      = ub_q;
  assign bus.unit_op     = uop_q;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_result  = res_q;
  assign bus.rsp_flags   = flg_q;
  assign bus.rsp_tag     = tag_q;
  assign bus.rsp_timeout = tmo_q;
  assign busy            = (state_q != IDLE) || (count_q != '0);
  assign fifo_count      = count_q;

  // Next-state, FIFO pointer/occupancy and command/response register updates.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wait_cnt_d = wait_cnt_q;
    ua_d       = ua_q;
    ub_d       = ub_q;
    uop_d      = uop_q;
    tag_d      = tag_q;
    res_d      = res_q;
    flg_d      = flg_q;
    tmo_d      = tmo_q;
    pop        = 1'b0;
    head       = mem_q[rd_ptr_q];
    push       = bus.cmd_valid && bus.cmd_ready;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          ua_d  = head[7:0];
          ub_d  = head[15:8];
          uop_d = head[17:16];
          tag_d = head[EW-1:18];
          if (head[17:16] == 2'b11) begin
            res_d   = 8'h00;
            flg_d   = 4'b1000;
            tmo_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // A done arriving on the final wait cycle still wins over the timeout.
        if (bus.unit_done) begin
          res_d   = bus.unit_result;
          flg_d   = bus.unit_flags;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
          if (wait_cnt_d == TW'(TIMEOUT)) begin
            res_d   = 8'h00;
            flg_d   = 4'b0000;
            tmo_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset abandons any in-flight command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      ua_q       <= '0;
      ub_q       <= '0;
      uop_q      <= '0;
      tag_q      <= '0;
      res_q      <= '0;
      flg_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      ua_q       <= ua_d;
      ub_q       <= ub_d;
      uop_q      <= uop_d;
      tag_q      <= tag_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
      tmo_q      <= tmo_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_tag, bus.cmd_op, bus.cmd_b, bus.cmd_a};
  end

`ifdef FP8_SCHED_STATS_EN
  logic        rsp_hs;
  logic [15:0] stat_done_q, stat_done_d;
  logic [7:0]  stat_to_q, stat_to_d;

  assign rsp_hs        = (state_q == RESP) && bus.rsp_ready;
  assign stat_done     = stat_done_q;
  assign stat_timeouts = stat_to_q;

  // Saturating response counters.
  always_comb begin
    stat_done_d = stat_done_q;
    stat_to_d   = stat_to_q;
    if (rsp_hs && (stat_done_q != 16'hFFFF)) stat_done_d = stat_done_q + 16'd1;
    if (rsp_hs && tmo_q && (stat_to_q != 8'hFF)) stat_to_d = stat_to_q + 8'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_done_q <= '0;
      stat_to_q   <= '0;
    end else begin
      stat_done_q <= stat_done_d;
      stat_to_q   <= stat_to_d;
    end
  end
`endif

endmodule

// File: tb/tb_fp8_cmd_sched.sv
// Bench for fp8_cmd_sched: directed scenarios plus randomized commands,
// unit latencies and response backpressure, checked against an in-order
// scoreboard of accepted commands and a behavioural stand-in for the FP8 unit.
module tb_fp8_cmd_sched;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [2:0] fifo_count;

  fp8_cmd_sched_if #(.TAG_W(TAG_W)) bus ();

`ifdef FP8_SCHED_STATS_EN
  logic [15:0] stat_done;
  logic [7:0]  stat_timeouts;
`endif

  fp8_cmd_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .busy       (busy),
    .fifo_count (fifo_count)
`ifdef FP8_SCHED_STATS_EN
    ,
    .stat_done     (stat_done),
    .stat_timeouts (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    int d;
    int s;
  } uo_t;

  cmd_t cmd_q[$];
  uo_t  unit_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in FP8 unit: exact values for the known cases, a fixed mix otherwise.
  function automatic logic [11:0] unit_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    logic [7:0] r;
    logic [3:0] f;
    if (op == 2'b00 && a == 8'h38 && b == 8'h38)      r = 8'h40;
    else if (op == 2'b10 && a == 8'h40 && b == 8'h40) r = 8'h48;
    else r = a ^ {b[3:0], b[7:4]} ^ {6'd0, op};
    f = {(r == 8'h00), a[7] & b[7], ~a[6] & ~b[6], a[0] ^ b[0]};
    return {f, r};
  endfunction

  // Unit model: d = wait cycle on which done is pulsed (0 = never).
  int force_d = -1;
  initial begin
    int d, k;
    bus.unit_done   = 1'b0;
    bus.unit_result = 8'h00;
    bus.unit_flags  = 4'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.unit_start && !reset) begin
        if (force_d >= 0) d = force_d;
        else begin
          k = $urandom_range(0, 7);
          d = (k == 0) ? 0 : (k <= 5) ? k : (k == 6) ? TIMEOUT : TIMEOUT + 1;
        end
        unit_q.push_back('{d: d, s: cyc});
        if (d != 0) begin
          repeat (d) begin @(posedge clk); #1; end
          {bus.unit_flags, bus.unit_result} = unit_fn(bus.unit_a, bus.unit_b, bus.unit_op);
          bus.unit_done = 1'b1;
          @(posedge clk); #1;
          bus.unit_done = 1'b0;
        end
      end
    end
  end

  // Response ready: fixed level or random backpressure.
  logic rdy_rand  = 1'b0;
  logic rdy_fixed = 1'b1;
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  end

  // Response scoreboard and protocol monitor.
  int n_start = 0, n_hs = 0, n_to = 0;
  bit saw_full = 1'b0, seen_rsp = 1'b0;
  initial begin
    logic pv, pr, ps, to;
    logic [16:0] snap, cur, e;
    logic [11:0] fr;
    int rise, lat;
    cmd_t c;
    uo_t u;
    pv = 0; pr = 0; ps = 0; snap = '0; rise = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur = {bus.rsp_tag, bus.rsp_timeout, bus.rsp_flags, bus.rsp_result};
        if (bus.rsp_valid) seen_rsp = 1'b1;
        if (fifo_count == 3'(DEPTH) && !bus.cmd_ready) saw_full = 1'b1;
        if (bus.unit_start) begin
          n_start++;
          chk("start_pulse_width", {31'd0, ps}, 0);
        end
        if (bus.rsp_valid && !pv) rise = cyc;
        if (bus.rsp_valid && pv && !pr) chk("rsp_hold_stable", {15'd0, cur}, {15'd0, snap});
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (cmd_q.size() == 0) chk("rsp_unexpected", 0, 1);
          else begin
            c = cmd_q.pop_front();
            if (c.op == 2'b11) begin
              e = {c.tag, 1'b0, 4'b1000, 8'h00};
              chk("rsp_fields", {15'd0, cur}, {15'd0, e});
              n_hs++;
            end else if (unit_q.size() == 0) begin
              chk("rsp_no_unit_start", 0, 1);
            end else begin
              u  = unit_q.pop_front();
              to = (u.d == 0) || (u.d > TIMEOUT);
              fr = unit_fn(c.a, c.b, c.op);
              e  = to ? {c.tag, 1'b1, 4'h0, 8'h00} : {c.tag, 1'b0, fr};
              lat = to ? TIMEOUT + 1 : u.d + 1;
              chk("rsp_latency", rise - u.s, lat);
              chk("rsp_fields", {15'd0, cur}, {15'd0, e});
              n_hs++;
              if (to) n_to++;
            end
          end
        end
        pv = bus.rsp_valid; pr = bus.rsp_ready; ps = bus.unit_start; snap = cur;
      end else begin
        pv = 0; pr = 0; ps = 0;
      end
    end
  end

  // Offer one command (call just after a rising edge); returns once accepted.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic [TAG_W-1:0] tag);
    int n;
    bit ok;
    n = 0; ok = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    if (ok) cmd_q.push_back('{a: a, b: b, op: op, tag: tag});
    else chk("push_accept_timeout", 0, 1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || busy) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {31'd0, (cmd_q.size() == 0 && !busy)}, 1);
  endtask

  task automatic chk_stats(input string tag);
`ifdef FP8_SCHED_STATS_EN
    chk({tag, "_stat_done"}, {16'd0, stat_done}, (n_hs > 65535) ? 32'hFFFF : n_hs);
    chk({tag, "_stat_timeouts"}, {24'd0, stat_timeouts}, (n_to > 255) ? 32'hFF : n_to);
`else
    chk({tag, "_busy_idle"}, {31'd0, busy}, 0);
`endif
  endtask

  initial begin
    int n0;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0; bus.cmd_tag = '0;

    // Power-on reset.
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rst_unit_start", {31'd0, bus.unit_start}, 0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    chk("rst_fifo_count", {29'd0, fifo_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_unit_ops", {14'd0, bus.unit_a, bus.unit_b, bus.unit_op}, 0);
    chk("rst_rsp_fields", {15'd0, bus.rsp_tag, bus.rsp_timeout, bus.rsp_flags, bus.rsp_result}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Single add: start pulse exactly in cycle 2 after the push cycle.
    force_d = 2;
    n0 = n_start;
    bus.cmd_valid = 1'b1; bus.cmd_a = 8'h38; bus.cmd_b = 8'h38; bus.cmd_op = 2'b00; bus.cmd_tag = 4'd3;
    @(posedge clk); #1;
    cmd_q.push_back('{a: 8'h38, b: 8'h38, op: 2'b00, tag: 4'd3});
    bus.cmd_valid = 1'b0;
    chk("lat_cycle1_start", {31'd0, bus.unit_start}, 0);
    @(posedge clk); #1;
    chk("lat_cycle2_start", {31'd0, bus.unit_start}, 1);
    @(posedge clk); #1;
    chk("lat_cycle3_start", {31'd0, bus.unit_start}, 0);
    wait_idle("t1_drain", 100);
    chk("t1_start_count", n_start - n0, 1);

    // Reset with commands queued and one command waiting on a silent unit.
    force_d = 0;
    push(8'h01, 8'h02, 2'b00, 4'd1);
    push(8'h03, 8'h04, 2'b01, 4'd2);
    push(8'h05, 8'h06, 2'b10, 4'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_count", {29'd0, fifo_count}, 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("mid_rst_unit_start", {31'd0, bus.unit_start}, 0);
    chk("mid_rst_fifo_count", {29'd0, fifo_count}, 0);
    chk("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    cmd_q.delete(); unit_q.delete();
    n_hs = 0; n_to = 0; seen_rsp = 1'b0;
    chk_stats("after_reset");
    @(negedge clk) reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("no_rsp_after_reset", {31'd0, seen_rsp}, 0);
    chk("idle_after_reset", {28'd0, busy, fifo_count}, 0);

    // DEPTH+1 commands, unit done 3 cycles after start.
    force_d = 3;
    saw_full = 1'b0;
    push(8'h38, 8'h38, 2'b00, 4'd1);
    push(8'h40, 8'h40, 2'b10, 4'd2);
    push(8'h5A, 8'h21, 2'b01, 4'd3);
    push(8'h7F, 8'h80, 2'b00, 4'd4);
    push(8'h40, 8'h40, 2'b10, 4'd5);
    wait_idle("t2_drain", 300);
    chk("t2_full_seen", {31'd0, saw_full}, 1);

    // Reserved opcode: no unit start.
    n0 = n_start;
    push(8'h11, 8'h22, 2'b11, 4'd9);
    wait_idle("t3_drain", 100);
    chk("t3_no_start", n_start - n0, 0);

    // Timeout, then done on the last wait cycle.
    force_d = 0;
    n0 = n_to;
    push(8'h12, 8'h34, 2'b00, 4'd6);
    wait_idle("t4_timeout_drain", 100);
    chk("t4_timeout_count", n_to - n0, 1);
    force_d = TIMEOUT;
    n0 = n_to;
    push(8'h38, 8'h38, 2'b00, 4'd7);
    wait_idle("t4_lastdone_drain", 100);
    chk("t4_lastdone_no_timeout", n_to - n0, 0);

    // Backpressure in RESP with two commands queued behind it.
    force_d = 2;
    rdy_fixed = 1'b0;
    push(8'h40, 8'h40, 2'b10, 4'd10);
    push(8'h38, 8'h38, 2'b00, 4'd11);
    push(8'h21, 8'h43, 2'b01, 4'd12);
    n0 = 0;
    while (!bus.rsp_valid && n0 < 50) begin @(posedge clk); #1; n0++; end
    chk("t5_rsp_reached", {31'd0, bus.rsp_valid}, 1);
    n0 = n_start;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_start_held", n_start - n0, 0);
    chk("t5_fifo_held", {29'd0, fifo_count}, 2);
    chk("t5_valid_held", {31'd0, bus.rsp_valid}, 1);
    rdy_fixed = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_no_start", {31'd0, bus.unit_start}, 0);
    @(posedge clk); #1;
    chk("t5_start_2_after_hs", {31'd0, bus.unit_start}, 1);
    wait_idle("t5_drain", 200);
    chk_stats("t5");

    // Randomized commands, unit latencies and response backpressure.
    force_d = -1;
    rdy_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      push(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), TAG_W'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_idle("rand_drain", 3000);
    rdy_rand = 1'b0;
    @(posedge clk); #1;
    chk_stats("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
